countdown_timer_bcd: RTL and testbench

- Parametrised, loadable BCD countdown timer for the quiz/answer-window logic.
- Counts down one step per external Tick enable (from the existing clock divider), with run/hold/clear control.
- Raises a sticky time-up flag and a low-time warning.
- BCD count drives the seven-segment digit decoders directly.

---
 rtl/countdown_timer_bcd.sv | 141 ++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// Loadable BCD countdown timer with run/hold/clear control, sticky time-up flag
// and a low-time warning; the BCD count feeds the seven-segment decoders directly.
module countdown_timer_bcd #(
  parameter int                   DIGITS = 2,
  parameter logic [4*DIGITS-1:0]  PRESET = 'h05,
  parameter logic [4*DIGITS-1:0]  WARN   = 'h03
) (
  input  logic                  CP,
  input  logic                  nCR,
  input  logic                  Tick,
  input  logic                  Start,
  input  logic                  Hold,
  input  logic                  Clr,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  t_up,
  output logic                  warn,
  output logic                  running
);

  localparam int CW = 4 * DIGITS;
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   reload_q, reload_d;
  logic            t_up_q, t_up_d;

  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple-borrow decrement: a zero digit becomes 9 and passes the borrow upward.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q  <= IDLE;
      count_q  <= PRESET;
      reload_q <= PRESET;
      t_up_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      t_up_q   <= t_up_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    t_up_d   = t_up_q;

    if (Clr) begin
      state_d = IDLE;
      count_d = reload_q;
      t_up_d  = 1'b0;
    end else if (Load && (state_q == IDLE)) begin
      reload_d = bcd_clamp(Load_val);
      count_d  = bcd_clamp(Load_val);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            if (count_q != ZERO) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              t_up_d  = 1'b1;
            end
          end
        end
        RUN: begin
          // Hold wins over a coincident Tick, so that Tick is simply lost.
          if (Hold) begin
            state_d = PAUSE;
          end else if (Tick) begin
            if ((count_q == ONE) || (count_q == ZERO)) begin
              count_d = ZERO;
              state_d = DONE;
              t_up_d  = 1'b1;
            end else begin
              count_d = bcd_dec(count_q);
            end
          end
        end
        PAUSE: begin
          if (!Hold) state_d = RUN;
        end
        DONE: begin
          if (Start && (reload_q != ZERO)) begin
            state_d = RUN;
            count_d = reload_q;
            t_up_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count   = count_q;
  assign state   = state_q;
  assign t_up    = t_up_q;
  assign running = (state_q == RUN) || (state_q == PAUSE);
  assign warn    = running && (count_q != ZERO) && (count_q <= WARN);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: per-cycle vector table fed through a scoreboard
// queue, plus hand-written async reset checks.
module tb_countdown_timer_bcd;

  logic       CP;
  logic       nCR;
  logic       Tick, Start, Hold, Clr, Load;
  logic [7:0] Load_val;
  logic [7:0] count;
  logic [1:0] state;
  logic       t_up, warn, running;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic       clr, load, start, hold, tick;
    logic [7:0] load_val;
    logic [7:0] exp_count;
    logic [1:0] exp_state;
    logic       exp_tup, exp_warn, exp_run;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  countdown_timer_bcd #(
    .DIGITS(2),
    .PRESET(8'h05),
    .WARN  (8'h03)
  ) dut (
    .CP      (CP),
    .nCR     (nCR),
    .Tick    (Tick),
    .Start   (Start),
    .Hold    (Hold),
    .Clr     (Clr),
    .Load    (Load),
    .Load_val(Load_val),
    .count   (count),
    .state   (state),
    .t_up    (t_up),
    .warn    (warn),
    .running (running)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input string nm, input logic c, input logic l, input logic s,
                     input logic h, input logic t, input logic [7:0] lv,
                     input logic [7:0] ec, input logic [1:0] es, input logic et,
                     input logic ew, input logic er);
    vec_t v;
    v.name = nm; v.clr = c; v.load = l; v.start = s; v.hold = h; v.tick = t;
    v.load_val = lv; v.exp_count = ec; v.exp_state = es;
    v.exp_tup = et; v.exp_warn = ew; v.exp_run = er;
    vecs.push_back(v);
  endtask

  // Idle cycles: no inputs, outputs must hold the previous row's expectation.
  task automatic add_gap(input int n);
    vec_t v;
    v = vecs[$];
    v.name = "gap"; v.clr = 0; v.load = 0; v.start = 0; v.hold = 0; v.tick = 0;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge CP);
    Clr = v.clr; Load = v.load; Start = v.start; Hold = v.hold; Tick = v.tick;
    Load_val = v.load_val;
    sb_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    total--;
    v = sb_q.pop_front();
    check_val({v.name, ".count"},   count,          v.exp_count);
    check_val({v.name, ".state"},   {6'd0, state},  {6'd0, v.exp_state});
    check_val({v.name, ".t_up"},    {7'd0, t_up},   {7'd0, v.exp_tup});
    check_val({v.name, ".warn"},    {7'd0, warn},   {7'd0, v.exp_warn});
    check_val({v.name, ".running"}, {7'd0, running}, {7'd0, v.exp_run});
  endtask

  initial begin
    logic [7:0] e;
    // Defaults run 05 down to 00, warn over 03..01.
    add("start",     0,0,1,0,0, 8'h00, 8'h05, 2'b01, 0,0,1);
    add("tick04",    0,0,0,0,1, 8'h00, 8'h04, 2'b01, 0,0,1); add_gap(3);
    add("tick03",    0,0,0,0,1, 8'h00, 8'h03, 2'b01, 0,1,1); add_gap(3);
    add("tick02",    0,0,0,0,1, 8'h00, 8'h02, 2'b01, 0,1,1); add_gap(3);
    add("tick01",    0,0,0,0,1, 8'h00, 8'h01, 2'b01, 0,1,1); add_gap(3);
    add("tick00",    0,0,0,0,1, 8'h00, 8'h00, 2'b11, 1,0,0);
    add("nowrap",    0,0,0,0,1, 8'h00, 8'h00, 2'b11, 1,0,0);
    add("done_hold", 0,0,0,1,1, 8'h00, 8'h00, 2'b11, 1,0,0);
    // Borrow across digits.
    add("clr",       1,0,0,0,0, 8'h00, 8'h05, 2'b00, 0,0,0);
    add("load20",    0,1,0,0,0, 8'h20, 8'h20, 2'b00, 0,0,0);
    add("idle_tick", 0,0,0,1,1, 8'h00, 8'h20, 2'b00, 0,0,0);
    add("start20",   0,0,1,0,0, 8'h00, 8'h20, 2'b01, 0,0,1);
    add("borrow19",  0,0,0,0,1, 8'h00, 8'h19, 2'b01, 0,0,1); add_gap(3);
    add("tick18",    0,0,0,0,1, 8'h00, 8'h18, 2'b01, 0,0,1);
    // Pause: coincident tick dropped, release edge never decrements.
    add("hold_tick", 0,0,0,1,1, 8'h00, 8'h18, 2'b10, 0,0,1);
    for (int i = 0; i < 3; i++)
      add("pause_tick", 0,0,0,1,1, 8'h00, 8'h18, 2'b10, 0,0,1);
    add("release",   0,0,0,0,1, 8'h00, 8'h18, 2'b01, 0,0,1);
    add("tick17",    0,0,0,0,1, 8'h00, 8'h17, 2'b01, 0,0,1);
    // Digit clamp and Load ignored outside IDLE.
    add("clr2",      1,0,0,0,0, 8'h00, 8'h20, 2'b00, 0,0,0);
    add("load3A",    0,1,0,0,0, 8'h3A, 8'h39, 2'b00, 0,0,0);
    add("start39",   0,0,1,0,0, 8'h00, 8'h39, 2'b01, 0,0,1);
    add("load_run",  0,1,0,0,0, 8'h50, 8'h39, 2'b01, 0,0,1);
    for (int n = 38; n >= 0; n--) begin
      e = {4'(n / 10), 4'(n % 10)};
      add("run_down", 0,0,0,0,1, 8'h00, e, (n == 0) ? 2'b11 : 2'b01,
          n == 0, (n >= 1) && (n <= 3), n != 0);
    end
    // Restart from DONE, then Clr beats Start.
    add("restart",   0,0,1,0,0, 8'h00, 8'h39, 2'b01, 0,0,1);
    add("tick38",    0,0,0,0,1, 8'h00, 8'h38, 2'b01, 0,0,1);
    add("clr_start", 1,0,1,0,0, 8'h00, 8'h39, 2'b00, 0,0,0);
    // Zero reload: Start goes straight to DONE and cannot leave it.
    add("load00",    0,1,0,0,0, 8'h00, 8'h00, 2'b00, 0,0,0);
    add("start0",    0,0,1,0,0, 8'h00, 8'h00, 2'b11, 1,0,0);
    add("restart0",  0,0,1,0,0, 8'h00, 8'h00, 2'b11, 1,0,0);
    add("clr0",      1,0,0,0,0, 8'h00, 8'h00, 2'b00, 0,0,0);
    add("loadF9_st", 0,1,1,0,0, 8'hF9, 8'h99, 2'b00, 0,0,0);
    add("start99",   0,0,1,0,0, 8'h00, 8'h99, 2'b01, 0,0,1);
    add("tick98",    0,0,0,0,1, 8'h00, 8'h98, 2'b01, 0,0,1);

    nCR = 1'b0; Tick = 0; Start = 0; Hold = 0; Clr = 0; Load = 0; Load_val = 8'h00;
    repeat (2) @(posedge CP);
    #1;
    check_val("rst.count", count, 8'h05);
    check_val("rst.state", {6'd0, state}, 8'h00);
    check_val("rst.t_up",  {7'd0, t_up}, 8'h00);
    check_val("rst.warn",  {7'd0, warn}, 8'h00);
    check_val("rst.running", {7'd0, running}, 8'h00);
    @(negedge CP);
    nCR = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge CP);
      #1;
      checkOutput();
    end

    // Reset mid-RUN must act before the next edge and leave nothing pending.
    @(negedge CP);
    Clr = 0; Load = 0; Hold = 0;
    #2;
    nCR = 1'b0; Tick = 1'b1; Start = 1'b1;
    #1;
    check_val("async.count", count, 8'h05);
    check_val("async.state", {6'd0, state}, 8'h00);
    check_val("async.t_up",  {7'd0, t_up}, 8'h00);
    check_val("async.running", {7'd0, running}, 8'h00);
    @(posedge CP);
    #1;
    check_val("inrst.count", count, 8'h05);
    @(negedge CP);
    nCR = 1'b1; Tick = 1'b0; Start = 1'b0;
    @(posedge CP);
    #1;
    check_val("post.count", count, 8'h05);
    check_val("post.state", {6'd0, state}, 8'h00);
    check_val("sb_empty", 8'(sb_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
